// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: UART receive front end. Synchronises the RX pin, detects
// the start-bit falling edge and issues the mid-bit start/data strobes (plus
// the sampled line level) consumed by the byte assembler downstream.
//
// Optional build macro: UART_RX_MAJORITY_EN
//   defined   - each sample is the 2-of-3 majority of the synchronised line
//               over the sample cycle and the two cycles before it.
//   undefined - each sample is the synchronised line at the sample cycle.
// Strobe timing is the same in both builds.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for a falling edge on the synchronised line with i_en=1
// START | timing half a bit to the middle of the start bit
// BITS  | timing full bits to the middle of 8 data bits and the stop bit

module uart_rx_sampler #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  input  logic i_rxd,
  output logic o_rx_start,
  output logic o_rx_pls,
  output logic o_rx_data,
  output logic o_busy
);

  localparam int HALF_BIT = CLKS_PER_BIT / 2;
  localparam int CW       = $clog2(CLKS_PER_BIT);

  localparam logic [CW-1:0] HALF_TC  = CW'(HALF_BIT - 1);
  localparam logic [CW-1:0] BIT_TC   = CW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]    LAST_BIT = 4'd8;

  typedef enum logic [1:0] {
    IDLE,
    START,
    BITS
  } state_t;

  state_t        state;
  logic [CW-1:0] baud_cnt;
  logic [3:0]    bit_cnt;

  logic rxd_m;
  logic rxd_s;
  logic rxd_d;
  logic fall;
  logic sample;

  // Two-flop synchroniser on the raw pin plus one delay flop for edge detect
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rxd_m <= 1'b1;
      rxd_s <= 1'b1;
      rxd_d <= 1'b1;
    end else begin
      rxd_m <= i_rxd;
      rxd_s <= rxd_m;
      rxd_d <= rxd_s;
    end
  end

  assign fall = rxd_d & ~rxd_s;

`ifdef UART_RX_MAJORITY_EN
  // hist[0] tracks rxd_s, hist[1] and hist[2] the two cycles before it
  logic [2:0] hist;

  // Shift the synchronised line into a 3-deep history for majority voting
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      hist <= 3'b111;
    end else begin
      hist <= {hist[1:0], rxd_m};
    end
  end

  assign sample = (hist[0] & hist[1]) | (hist[0] & hist[2]) | (hist[1] & hist[2]);
`else
  assign sample = rxd_s;
`endif

  // Frame sequencer: baud/bit counting and registered strobe outputs
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= IDLE;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      o_rx_start <= 1'b0;
      o_rx_pls   <= 1'b0;
      o_rx_data  <= 1'b1;
      o_busy     <= 1'b0;
    end else begin
      o_rx_start <= 1'b0;
      o_rx_pls   <= 1'b0;
      case (state)
        IDLE: begin
          baud_cnt <= '0;
          bit_cnt  <= '0;
          if (i_en && fall) begin
            state  <= START;
            o_busy <= 1'b1;
          end
        end

        START: begin
          if (!i_en) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            o_busy   <= 1'b0;
          end else if (baud_cnt == HALF_TC) begin
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            o_rx_start <= 1'b1;
            o_rx_data  <= sample;
            // A high start sample is a false start; the assembler still gets
            // the strobe so it can flag it, but no data bits follow.
            if (sample) begin
              state  <= IDLE;
              o_busy <= 1'b0;
            end else begin
              state <= BITS;
            end
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end

        BITS: begin
          if (!i_en) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            o_busy   <= 1'b0;
          end else if (baud_cnt == BIT_TC) begin
            baud_cnt  <= '0;
            o_rx_pls  <= 1'b1;
            o_rx_data <= sample;
            // Leave at the stop-bit sample rather than waiting it out so a
            // back-to-back start edge is not missed.
            if (bit_cnt == LAST_BIT) begin
              bit_cnt <= '0;
              state   <= IDLE;
              o_busy  <= 1'b0;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end

        default: begin
          state    <= IDLE;
          baud_cnt <= '0;
          bit_cnt  <= '0;
          o_busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule
